// File: rtl/z80_snd_bus.sv
// rtl/z80_snd_bus.sv - sound Z80 bus stage: map decode, work RAM, cached ROM front-end, command latch
// Sits between the T80 wrapper and the ROM/YM2151/K007232 interfaces.
module z80_snd_bus #(
  parameter int RAM_AW = 11,
  parameter int ROM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       z80_addr,
  input  logic [7:0]        z80_dout,
  output logic [7:0]        z80_din,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  output logic              nINT,
  output logic              nWAIT,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  input  logic              cmd_wr,
  input  logic [7:0]        cmd_data,
  input  logic [7:0]        ym_din,
  output logic              ym_wr,
  output logic              ym_a0,
  input  logic [7:0]        k7232_din,
  output logic              k7232_wr,
  output logic [3:0]        k7232_a,
  output logic [7:0]        ctrl_reg
);

  typedef enum logic [2:0] {R_ROM, R_RAM, R_CTRL, R_LATCH, R_K7232, R_YM, R_NONE} region_t;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} rom_state_t;

  region_t           region;
  rom_state_t        state_q;
  logic              mem_rd;
  logic              rom_rd_act;
  logic              hit;
  logic              wr_evt;
  logic              ack;
  logic              nwr_q;
  logic              rom_req_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              valid_q;
  logic [ROM_AW-1:0] tag_q;
  logic [7:0]        data_q;
  logic [7:0]        ram_q [0:(1<<RAM_AW)-1];
  logic [7:0]        ram_rd_q;
  logic [7:0]        ctrl_q;
  logic [7:0]        latch_q;
  logic              int_pend_q;
  logic              ym_wr_q;
  logic              ym_a0_q;
  logic              k_wr_q;
  logic [3:0]        k_a_q;

  always_comb begin
    region = R_NONE;
    case (z80_addr[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: region = R_ROM;
      4'h8:    region = R_RAM;
      4'h9:    region = R_CTRL;
      4'hA:    region = R_LATCH;
      4'hB:    region = R_K7232;
      4'hC:    region = R_YM;
      default: region = R_NONE;
    endcase
  end

  assign mem_rd     = ~nMREQ & ~nRD;
  assign rom_rd_act = mem_rd & (region == R_ROM);
  assign hit        = valid_q & (tag_q == z80_addr[ROM_AW-1:0]);
  assign nWAIT      = ~(rom_rd_act & ~hit);
  // One event per nWR assertion: only the first low cycle after a high one counts.
  assign wr_evt     = nwr_q & ~nWR & ~nMREQ;
  assign ack        = ~nIORQ & nRD & nWR;

  always_comb begin
    z80_din = 8'hFF;
    if (mem_rd) begin
      case (region)
        R_ROM:   z80_din = data_q;
        R_RAM:   z80_din = ram_rd_q;
        R_LATCH: z80_din = latch_q;
        R_K7232: z80_din = k7232_din;
        R_YM:    z80_din = ym_din;
        default: z80_din = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_evt && region == R_RAM) begin
      ram_q[z80_addr[RAM_AW-1:0]] <= z80_dout;
    end
    ram_rd_q <= ram_q[z80_addr[RAM_AW-1:0]];
  end

  // ROM fetch FSM and one-entry cache; a reset mid-fetch drops back to IDLE so a late rom_ok is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      data_q     <= 8'h00;
    end else begin
      rom_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rom_rd_act && !hit) begin
            rom_req_q  <= 1'b1;
            valid_q    <= 1'b0;
            rom_addr_q <= z80_addr[ROM_AW-1:0];
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rom_ok) begin
            tag_q   <= rom_addr_q;
            data_q  <= rom_data;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!rom_rd_act) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nwr_q      <= 1'b1;
      ctrl_q     <= 8'h00;
      latch_q    <= 8'h00;
      int_pend_q <= 1'b0;
      ym_wr_q    <= 1'b0;
      ym_a0_q    <= 1'b0;
      k_wr_q     <= 1'b0;
      k_a_q      <= 4'h0;
    end else begin
      nwr_q   <= nWR;
      ym_wr_q <= wr_evt && region == R_YM;
      k_wr_q  <= wr_evt && region == R_K7232;
      if (wr_evt && region == R_YM)    ym_a0_q <= z80_addr[0];
      if (wr_evt && region == R_K7232) k_a_q   <= z80_addr[3:0];
      if (wr_evt && region == R_CTRL)  ctrl_q  <= z80_dout;
      // A new command outranks a coincident acknowledge.
      if (cmd_wr) begin
        latch_q    <= cmd_data;
        int_pend_q <= 1'b1;
      end else if (ack) begin
        int_pend_q <= 1'b0;
      end
    end
  end

  assign nINT     = ~int_pend_q;
  assign rom_req  = rom_req_q;
  assign rom_addr = rom_addr_q;
  assign ym_wr    = ym_wr_q;
  assign ym_a0    = ym_a0_q;
  assign k7232_wr = k_wr_q;
  assign k7232_a  = k_a_q;
  assign ctrl_reg = ctrl_q;

endmodule
